// File: rtl/ir_nec_rx_fifo.sv
// NEC IR receiver: synchroniser, glitch filter, pulse-width FSM and frame FIFO.
// Repeat codes replay the last good data frame into the FIFO.
module ir_nec_rx_fifo #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GLITCH_FILT = 4,
  parameter bit CHECK_INV   = 1'b1,
  parameter bit REPEAT_EN   = 1'b1,
  parameter int FIFO_DEPTH  = 4,
  parameter bit RX_ACT_LOW  = 1'b1
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iIRDA,
  input  logic                          iREAD,
  output logic [31:0]                   oDATA,
  output logic                          oREPEAT,
  output logic                          oDATA_READY,
  output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
  output logic                          oERR,
  output logic                          oOVF
);

  localparam int TICK_DIV = CLK_HZ / 100_000;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int FW = $clog2(GLITCH_FILT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [11:0] LM_MIN = 12'd675;
  localparam logic [11:0] LM_MAX = 12'd1125;
  localparam logic [11:0] LD_MIN = 12'd338;
  localparam logic [11:0] LD_MAX = 12'd562;
  localparam logic [11:0] LR_MIN = 12'd169;
  localparam logic [11:0] LR_MAX = 12'd281;
  localparam logic [11:0] BM_MIN = 12'd28;
  localparam logic [11:0] BM_MAX = 12'd84;
  localparam logic [11:0] S0_MAX = 12'd112;
  localparam logic [11:0] S1_MAX = 12'd225;
  localparam logic [11:0] W_SAT  = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LMARK, S_LSPACE, S_BMARK, S_BSPACE, S_EMARK, S_RMARK
  } state_t;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic [1:0]    sync;
  logic          lvl;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          flip;
  logic [11:0]   wcnt;
  state_t        state, state_n;
  logic          shift, bit_val, cm_data, cm_rpt, err_fsm;
  logic [4:0]    bcnt;
  logic [31:0]   data, last;
  logic          last_valid, cm_data_q, cm_rpt_q;
  logic          inv_ok, push, err_n;
  logic [32:0]   push_word;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          empty, full, pop, wr, ovf_n;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  // 10 us tick prescaler
  always_ff @(posedge iCLK) begin
    if (iRST || tick) tcnt <= '0;
    else              tcnt <= tcnt + 1'b1;
  end

  // two-flop synchroniser, reset to the idle (no carrier) level
  always_ff @(posedge iCLK) begin
    if (iRST) sync <= {2{RX_ACT_LOW}};
    else      sync <= {sync[0], iIRDA};
  end

  // lvl = 1 means carrier present (mark)
  assign lvl  = RX_ACT_LOW ? ~sync[1] : sync[1];
  assign flip = tick && (lvl != filt) && (fcnt == FW'(GLITCH_FILT));

  // filtered level flips only after the new level survives the hold time
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (tick) begin
      if (flip) begin
        filt <= ~filt;
        fcnt <= '0;
      end else if (lvl != filt) begin
        fcnt <= fcnt + 1'b1;
      end else begin
        fcnt <= '0;
      end
    end
  end

  // saturating width of the current filtered level, in ticks
  always_ff @(posedge iCLK) begin
    if (iRST || flip)              wcnt <= '0;
    else if (tick && wcnt != W_SAT) wcnt <= wcnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_n;
  end

  // pulse-width classification on every filtered edge
  always_comb begin
    state_n = state;
    shift   = 1'b0;
    bit_val = 1'b0;
    cm_data = 1'b0;
    cm_rpt  = 1'b0;
    err_fsm = 1'b0;
    case (state)
      S_IDLE: if (flip && !filt) state_n = S_LMARK;
      S_LMARK: if (flip) begin
        if (wcnt >= LM_MIN && wcnt <= LM_MAX) begin
          state_n = S_LSPACE;
        end else begin
          state_n = S_IDLE;
          err_fsm = (wcnt > LM_MAX);
        end
      end
      S_LSPACE: if (flip) begin
        if (wcnt >= LD_MIN && wcnt <= LD_MAX) begin
          state_n = S_BMARK;
        end else if (wcnt >= LR_MIN && wcnt <= LR_MAX) begin
          state_n = S_RMARK;
        end else begin
          state_n = S_IDLE;
          err_fsm = 1'b1;
        end
      end
      S_BMARK: if (flip) begin
        if (wcnt >= BM_MIN && wcnt <= BM_MAX) begin
          state_n = S_BSPACE;
        end else begin
          state_n = S_IDLE;
          err_fsm = 1'b1;
        end
      end
      S_BSPACE: if (flip) begin
        if (wcnt >= BM_MIN && wcnt <= S1_MAX) begin
          shift   = 1'b1;
          bit_val = (wcnt > S0_MAX);
          state_n = (bcnt == 5'd31) ? S_EMARK : S_BMARK;
        end else begin
          state_n = S_IDLE;
          err_fsm = 1'b1;
        end
      end
      S_EMARK, S_RMARK: if (flip) begin
        state_n = S_IDLE;
        if (wcnt >= BM_MIN && wcnt <= BM_MAX) begin
          cm_data = (state == S_EMARK);
          cm_rpt  = (state == S_RMARK);
        end else begin
          err_fsm = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE && wcnt == W_SAT) begin
      state_n = S_IDLE;
      err_fsm = 1'b1;
    end
  end

  // bit assembly, LSB first
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bcnt <= '0;
      data <= '0;
    end else begin
      if (state == S_IDLE) bcnt <= '0;
      else if (shift)      bcnt <= bcnt + 1'b1;
      if (shift) data[bcnt] <= bit_val;
    end
  end

  assign inv_ok = !CHECK_INV || (data[31:24] == ~data[23:16]);
  assign push = (cm_data_q && inv_ok) ||
                (cm_rpt_q && REPEAT_EN && last_valid);
  assign push_word = cm_rpt_q ? {1'b1, last} : {1'b0, data};
  assign err_n = err_fsm || (cm_data_q && !inv_ok);

  // commit stage: delayed frame-done strobes and last good frame
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cm_data_q  <= 1'b0;
      cm_rpt_q   <= 1'b0;
      last       <= '0;
      last_valid <= 1'b0;
    end else begin
      cm_data_q <= cm_data;
      cm_rpt_q  <= cm_rpt;
      if (cm_data_q && inv_ok) begin
        last       <= data;
        last_valid <= 1'b1;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = iREAD && !empty;
  assign wr    = push && (!full || pop);
  assign ovf_n = push && full && !pop;

  // FIFO pointers and occupancy
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {repeat, data}
  always_ff @(posedge iCLK) begin
    if (wr) mem[wp] <= push_word;
  end

  // one-cycle status pulses
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oERR <= 1'b0;
      oOVF <= 1'b0;
    end else begin
      oERR <= err_n;
      oOVF <= ovf_n;
    end
  end

  assign oDATA       = empty ? 32'd0 : mem[rp][31:0];
  assign oREPEAT     = !empty && mem[rp][32];
  assign oDATA_READY = !empty;
  assign oCOUNT      = count;

endmodule
